uart_tx: RTL

UART transmitter for the PicoRV32 SoC. It accepts bytes from the SoC-side producer (the CPU peripheral interconnect) over a valid/ready handshake and buffers them in a small FIFO. It serializes them as 8N1 frames onto the SoC's serial output, which the top-level exposes as `o_uart_rx` (the host's receive line). It is the stage directly upstream of that top-level pin.

---
 rtl/uart_tx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter with a valid/ready byte input.
module uart_tx #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [7:0]                         i_data,
    output logic                               o_uart_rx,
    output logic                               o_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               line_q, line_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic               push;
    logic               pop;
    logic               baud_last;
    logic               fifo_nonempty;

    assign o_ready       = (count_q != CNT_W'(FIFO_DEPTH));
    assign o_busy        = (state_q != S_IDLE) || (count_q != '0);
    assign o_fifo_count  = count_q;
    assign o_uart_rx     = line_q;

    assign push          = i_valid && o_ready;
    assign baud_last     = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign fifo_nonempty = (count_q != '0);

    // Next-state, serializer and FIFO bookkeeping
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        line_d  = line_q;
        pop     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                line_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    state_d = S_START;
                    baud_d  = '0;
                    line_d  = 1'b0;
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    line_d  = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        line_d  = 1'b1;
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        line_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next frame when data is waiting
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = S_START;
                        line_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        line_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                line_d  = 1'b1;
            end
        endcase
    end

    // FIFO pointer and occupancy updates
    always_comb begin
        wptr_d  = push ? (wptr_q + PTR_W'(1)) : wptr_q;
        rptr_d  = pop  ? (rptr_q + PTR_W'(1)) : rptr_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // State and datapath registers; reset aborts any frame and drops buffered bytes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            line_q  <= line_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wptr_q] <= i_data;
        end
    end

endmodule
